// File: rtl/pipeline_sequencer.sv
// Hazard/sequencing unit for the 5-stage MIPS pipeline: load-use stall, branch/jump flush, dmem wait, halt drain.
// Latency: all control outputs are combinational from state + inputs; state advances on the rising clk edge.
// Backpressure: mem_req & !mem_ready freezes the whole pipeline and the sequencer state until mem_ready.
//
// Optional feature: define PERF_CNT_EN to build the saturating stall_cycles counter (otherwise tied to 0).
//
// Ports:
//   clk, rst_b                      clock, asynchronous active-low reset
//   id_instruction                  instruction currently in ID
//   idex_mem_read, idex_rt          lw in ID/EX and its destination register
//   ex_branch_taken                 beq in EX resolved taken
//   mem_req, mem_ready              data-memory handshake from EX/MEM
//   pc_write, ifid_write, ifid_flush  front-end enables
//   stall_b                         0 = decode controller inserts a bubble into ID/EX
//   pipe_freeze                     1 = ID/EX, EX/MEM, MEM/WB hold
//   halted                          pipeline drained and stopped
//   stall_cycles                    cycles with pc_write low (perf counter)
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      id_instruction,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             stall_b,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;

  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       rt_is_source;
  logic       load_use;
  logic       mem_wait;

  assign id_opcode = id_instruction[31:26];
  assign id_rs     = id_instruction[25:21];
  assign id_rt     = id_instruction[20:16];

  // Only R-type, beq and sw read rt as a source; for lw/addi etc. rt is a destination.
  assign rt_is_source = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) || (id_opcode == OP_SW);
  assign load_use     = idex_mem_read && (idex_rt != 5'd0) &&
                        ((idex_rt == id_rs) || ((idex_rt == id_rt) && rt_is_source));
  assign mem_wait     = mem_req && !mem_ready && (state != HALTED);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    stall_b       = 1'b1;
    pipe_freeze   = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;

    if (!rst_b) begin
      // Hold the pipeline quiet while reset is asserted, independent of the clock.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      stall_b     = 1'b0;
      pipe_freeze = 1'b1;
    end else if (mem_wait) begin
      // Whole pipeline holds; state and drain count are untouched.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (state == HALTED) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      stall_b     = 1'b0;
      pipe_freeze = 1'b1;
      halted      = 1'b1;
    end else if (ex_branch_taken) begin
      // Flushing ID also removes any load-use consumer, so no stall is needed.
      ifid_flush = 1'b1;
      stall_b    = 1'b0;
      if (state == DRAIN) begin
        state_nxt     = RUN;
        drain_cnt_nxt = 4'd0;
      end
    end else if (state == DRAIN) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      stall_b       = 1'b0;
      drain_cnt_nxt = drain_cnt - 4'd1;
      if (drain_cnt == 4'd1) begin
        state_nxt = HALTED;
      end
    end else if (id_opcode == OP_HALT) begin
      // Halt itself goes down the pipe as a nop; fetch stops here.
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      state_nxt     = DRAIN;
      drain_cnt_nxt = DRAIN_INIT;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      stall_b    = 1'b0;
    end else if (id_opcode == OP_JUMP) begin
      ifid_flush = 1'b1;
    end

    // Recover from an unused state encoding.
    if (rst_b && (state != RUN) && (state != DRAIN) && (state != HALTED)) begin
      state_nxt     = RUN;
      drain_cnt_nxt = 4'd0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt <= '0;
    end else if ((state != HALTED) && !pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
